ex_shift_issue: RTL and testbench

Single-entry ID/EX pipeline stage that captures a decoded instruction from decode and drives the execute-stage shifter's operand, shift-amount and shift-type inputs. It resolves RAW hazards by forwarding from the EX/MEM and MEM/WB results, both at capture and on every cycle an entry is held. It presents a valid/ready handshake on both sides and supports a synchronous flush.

---
 rtl/ex_shift_issue.sv | 195 +++++++++++++++++++
 tb/tb_ex_shift_issue.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/ex_shift_issue.sv
// ex_shift_issue
//   This is a single-entry ID/EX stage that sits in front of the execute-stage
//   shifter. It captures one decoded instruction and forwards RAW hazards
//   from the EX/MEM and MEM/WB results. Forwarding happens when the entry is
//   captured and again on every cycle the entry is held. The stage uses a
//   valid/ready handshake on both sides and has a synchronous flush.
//
// Ports
//   clk, rst_n          rising-edge clock, asynchronous active-low reset
//   flush               drops the held entry and blocks this cycle's capture
//   in_valid/in_ready   handshake with decode
//   in_rs1/rs2/rd_addr  register indices
//   in_rs1/rs2_data     register-file read data
//   in_imm, in_funct3, in_funct7b5, in_use_imm, in_is_shift, in_is_lui,
//   in_reg_write        decoded instruction fields
//   exmem_*, memwb_*    forwarding sources (index, write enable, result)
//   out_valid/out_ready handshake with execute
//   out_a, out_shamt, out_typ, out_is_shift, out_rd, out_reg_write
//                       registered shifter payload
//
// Configuration
//   EX_SHIFT_ISSUE_PERF_EN  adds the output stall_cycles. It is a saturating
//                           count of cycles with out_valid && !out_ready.

module ex_shift_issue #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [4:0]      in_rs1_addr,
    input  logic [4:0]      in_rs2_addr,
    input  logic [4:0]      in_rd_addr,
    input  logic [XLEN-1:0] in_rs1_data,
    input  logic [XLEN-1:0] in_rs2_data,
    input  logic [XLEN-1:0] in_imm,
    input  logic [2:0]      in_funct3,
    input  logic            in_funct7b5,
    input  logic            in_use_imm,
    input  logic            in_is_shift,
    input  logic            in_is_lui,
    input  logic            in_reg_write,
    input  logic [4:0]      exmem_rd,
    input  logic [4:0]      memwb_rd,
    input  logic            exmem_reg_write,
    input  logic            memwb_reg_write,
    input  logic [XLEN-1:0] exmem_result,
    input  logic [XLEN-1:0] memwb_result,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_a,
    output logic [4:0]      out_shamt,
    output logic [1:0]      out_typ,
    output logic            out_is_shift,
    output logic [4:0]      out_rd,
    output logic            out_reg_write
`ifdef EX_SHIFT_ISSUE_PERF_EN
    ,
    output logic [31:0]     stall_cycles
`endif
);

    typedef enum logic [1:0] {
        TYP_SLL = 2'b00,
        TYP_SRL = 2'b01,
        TYP_SRA = 2'b10,
        TYP_LUI = 2'b11
    } shift_typ_e;

    // EX/MEM takes priority over MEM/WB. x0 is never forwarded.
    function automatic logic [XLEN-1:0] fwd(
        input logic [4:0]      addr,
        input logic [XLEN-1:0] data,
        input logic [4:0]      em_rd,
        input logic            em_we,
        input logic [XLEN-1:0] em_res,
        input logic [4:0]      mw_rd,
        input logic            mw_we,
        input logic [XLEN-1:0] mw_res
    );
        if (addr == 5'd0)                  return data;
        else if (em_we && em_rd == addr)   return em_res;
        else if (mw_we && mw_rd == addr)   return mw_res;
        else                               return data;
    endfunction

    // Held copies needed to re-forward while the entry stalls.
    logic [4:0]      held_rs1_addr;
    logic [4:0]      held_rs2_addr;
    logic [XLEN-1:0] held_rs2;
    logic            a_from_rs1;      // out_a tracks rs1 (not LUI)
    logic            shamt_from_rs2;  // out_shamt tracks rs2 operand

    logic            capture;
    logic            consume;
    logic            hold;
    logic [XLEN-1:0] cap_rs1;
    logic [XLEN-1:0] cap_rs2;
    logic [XLEN-1:0] cap_a;
    logic [4:0]      cap_shamt;
    logic            cap_uses_shifter;
    shift_typ_e      cap_typ;
    logic [XLEN-1:0] hold_rs1;
    logic [XLEN-1:0] hold_rs2;

    assign in_ready = !out_valid || out_ready;
    assign capture  = in_valid && in_ready && !flush;
    assign consume  = out_valid && out_ready;
    assign hold     = out_valid && !out_ready;

    assign cap_rs1 = fwd(in_rs1_addr, in_rs1_data, exmem_rd, exmem_reg_write,
                         exmem_result, memwb_rd, memwb_reg_write, memwb_result);
    assign cap_rs2 = fwd(in_rs2_addr, in_rs2_data, exmem_rd, exmem_reg_write,
                         exmem_result, memwb_rd, memwb_reg_write, memwb_result);

    // While the entry is held, out_a still carries the rs1 operand (non-LUI).
    // That lets the held data be refreshed in place.
    assign hold_rs1 = fwd(held_rs1_addr, out_a, exmem_rd, exmem_reg_write,
                          exmem_result, memwb_rd, memwb_reg_write, memwb_result);
    assign hold_rs2 = fwd(held_rs2_addr, held_rs2, exmem_rd, exmem_reg_write,
                          exmem_result, memwb_rd, memwb_reg_write, memwb_result);

    assign cap_uses_shifter = in_is_shift || in_is_lui;
    assign cap_a            = in_is_lui ? in_imm : cap_rs1;

    always_comb begin
        cap_shamt = '0;
        if (cap_uses_shifter)
            cap_shamt = in_use_imm ? in_imm[4:0] : cap_rs2[4:0];
    end

    always_comb begin
        cap_typ = TYP_SLL;
        if (in_is_lui)
            cap_typ = TYP_LUI;
        else if (in_funct3 == 3'b101)
            cap_typ = in_funct7b5 ? TYP_SRA : TYP_SRL;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid      <= 1'b0;
            out_a          <= '0;
            out_shamt      <= '0;
            out_typ        <= '0;
            out_is_shift   <= 1'b0;
            out_rd         <= '0;
            out_reg_write  <= 1'b0;
            held_rs1_addr  <= '0;
            held_rs2_addr  <= '0;
            held_rs2       <= '0;
            a_from_rs1     <= 1'b0;
            shamt_from_rs2 <= 1'b0;
        end else begin
            if (flush)
                out_valid <= 1'b0;
            else if (capture)
                out_valid <= 1'b1;
            else if (consume)
                out_valid <= 1'b0;

            if (capture) begin
                out_a          <= cap_a;
                out_shamt      <= cap_shamt;
                out_typ        <= cap_typ;
                out_is_shift   <= cap_uses_shifter;
                out_rd         <= in_rd_addr;
                out_reg_write  <= in_reg_write;
                held_rs1_addr  <= in_rs1_addr;
                held_rs2_addr  <= in_rs2_addr;
                held_rs2       <= cap_rs2;
                a_from_rs1     <= !in_is_lui;
                shamt_from_rs2 <= cap_uses_shifter && !in_use_imm;
            end else if (hold) begin
                held_rs2 <= hold_rs2;
                if (a_from_rs1)
                    out_a <= hold_rs1;
                if (shamt_from_rs2)
                    out_shamt <= hold_rs2[4:0];
            end
        end
    end

`ifdef EX_SHIFT_ISSUE_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            stall_cycles <= '0;
        else if (hold && stall_cycles != '1)
            stall_cycles <= stall_cycles + 32'd1;
    end
`endif

endmodule

// File: tb/tb_ex_shift_issue.sv
// tb_ex_shift_issue
//   Directed self-checking bench for ex_shift_issue. Each step's expected
//   values are hand-computed constants. When EX_SHIFT_ISSUE_PERF_EN is defined,
//   the bench also checks the stall counter.

module tb_ex_shift_issue;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_rs1_addr, in_rs2_addr, in_rd_addr;
    logic [31:0] in_rs1_data, in_rs2_data, in_imm;
    logic [2:0]  in_funct3;
    logic        in_funct7b5, in_use_imm, in_is_shift, in_is_lui, in_reg_write;
    logic [4:0]  exmem_rd, memwb_rd;
    logic        exmem_reg_write, memwb_reg_write;
    logic [31:0] exmem_result, memwb_result;
    logic        out_valid, out_ready;
    logic [31:0] out_a;
    logic [4:0]  out_shamt;
    logic [1:0]  out_typ;
    logic        out_is_shift;
    logic [4:0]  out_rd;
    logic        out_reg_write;
`ifdef EX_SHIFT_ISSUE_PERF_EN
    logic [31:0] stall_cycles;
`endif

    int unsigned errors = 0;
    int unsigned checks = 0;

    ex_shift_issue #(.XLEN(32)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .flush           (flush),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_rs1_addr     (in_rs1_addr),
        .in_rs2_addr     (in_rs2_addr),
        .in_rd_addr      (in_rd_addr),
        .in_rs1_data     (in_rs1_data),
        .in_rs2_data     (in_rs2_data),
        .in_imm          (in_imm),
        .in_funct3       (in_funct3),
        .in_funct7b5     (in_funct7b5),
        .in_use_imm      (in_use_imm),
        .in_is_shift     (in_is_shift),
        .in_is_lui       (in_is_lui),
        .in_reg_write    (in_reg_write),
        .exmem_rd        (exmem_rd),
        .memwb_rd        (memwb_rd),
        .exmem_reg_write (exmem_reg_write),
        .memwb_reg_write (memwb_reg_write),
        .exmem_result    (exmem_result),
        .memwb_result    (memwb_result),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_a           (out_a),
        .out_shamt       (out_shamt),
        .out_typ         (out_typ),
        .out_is_shift    (out_is_shift),
        .out_rd          (out_rd),
        .out_reg_write   (out_reg_write)
`ifdef EX_SHIFT_ISSUE_PERF_EN
        ,
        .stall_cycles    (stall_cycles)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge, then settle away from it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        flush = 0; in_valid = 0;
        in_rs1_addr = 0; in_rs2_addr = 0; in_rd_addr = 0;
        in_rs1_data = 0; in_rs2_data = 0; in_imm = 0;
        in_funct3 = 0; in_funct7b5 = 0; in_use_imm = 0;
        in_is_shift = 0; in_is_lui = 0; in_reg_write = 0;
        exmem_rd = 0; memwb_rd = 0; exmem_reg_write = 0; memwb_reg_write = 0;
        exmem_result = 0; memwb_result = 0;
    endtask

    initial begin
        clear_inputs();
        out_ready = 1;
        rst_n = 0;
        tick(); tick();

        // Reset state
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_a", out_a, 32'd0);
        chk("rst_shamt", {27'd0, out_shamt}, 32'd0);
        chk("rst_typ", {30'd0, out_typ}, 32'd0);
        chk("rst_is_shift", {31'd0, out_is_shift}, 32'd0);
        chk("rst_rd", {27'd0, out_rd}, 32'd0);
        chk("rst_reg_write", {31'd0, out_reg_write}, 32'd0);
`ifdef EX_SHIFT_ISSUE_PERF_EN
        chk("rst_stall", stall_cycles, 32'd0);
`endif
        rst_n = 1;
        tick();

        // SRAI x9, x3, 4
        in_valid = 1; in_funct3 = 3'b101; in_funct7b5 = 1; in_use_imm = 1;
        in_imm = 32'd4; in_rs1_addr = 5'd3; in_rs1_data = 32'h8000_0000;
        in_rs2_data = 32'h0000_0013; in_is_shift = 1; in_reg_write = 1; in_rd_addr = 5'd9;
        tick();
        clear_inputs();
        chk("srai_valid", {31'd0, out_valid}, 32'd1);
        chk("srai_typ", {30'd0, out_typ}, 32'd2);
        chk("srai_shamt", {27'd0, out_shamt}, 32'd4);
        chk("srai_a", out_a, 32'h8000_0000);
        chk("srai_rd", {27'd0, out_rd}, 32'd9);
        chk("srai_is_shift", {31'd0, out_is_shift}, 32'd1);
        tick();
        chk("srai_consumed", {31'd0, out_valid}, 32'd0);

        // Forwarding: EX/MEM beats MEM/WB for the same index
        in_valid = 1; in_funct3 = 3'b001; in_is_shift = 1; in_use_imm = 1; in_imm = 32'd2;
        in_rs1_addr = 5'd5; in_rs1_data = 32'h0000_AAAA; in_rd_addr = 5'd1;
        exmem_rd = 5'd5; exmem_reg_write = 1; exmem_result = 32'h11;
        memwb_rd = 5'd5; memwb_reg_write = 1; memwb_result = 32'h22;
        tick();
        chk("fwd_exmem_a", out_a, 32'h11);
        chk("fwd_sll_typ", {30'd0, out_typ}, 32'd0);
        // x0 source, both forwarders aimed at x0: register data wins
        in_rs1_addr = 5'd0; in_rs1_data = 32'h55; in_rd_addr = 5'd2;
        exmem_rd = 5'd0; memwb_rd = 5'd0;
        tick();
        chk("fwd_x0_a", out_a, 32'h55);
        chk("fwd_x0_rd", {27'd0, out_rd}, 32'd2);
        // MEM/WB only match
        in_rs1_addr = 5'd6; in_rs1_data = 32'h77; in_rd_addr = 5'd3;
        exmem_rd = 5'd5; memwb_rd = 5'd6;
        tick();
        chk("fwd_memwb_a", out_a, 32'h22);
        clear_inputs();
        tick();

        // Hold refresh: SLL with shamt from rs2 (x7)
        out_ready = 0;
        in_valid = 1; in_funct3 = 3'b001; in_is_shift = 1; in_use_imm = 0;
        in_rs2_addr = 5'd7; in_rs2_data = 32'd3; in_rs1_addr = 5'd4; in_rs1_data = 32'h0F;
        in_rd_addr = 5'd8; in_reg_write = 1;
        tick();
        clear_inputs();
        chk("hold_shamt_init", {27'd0, out_shamt}, 32'd3);
        chk("hold_in_ready", {31'd0, in_ready}, 32'd0);
        memwb_rd = 5'd7; memwb_reg_write = 1; memwb_result = 32'h1F;
        tick();
        chk("hold_shamt_fwd", {27'd0, out_shamt}, 32'd31);
        chk("hold_valid", {31'd0, out_valid}, 32'd1);
        chk("hold_a_kept", out_a, 32'h0F);
        tick(); tick();
`ifdef EX_SHIFT_ISSUE_PERF_EN
        chk("stall_3", stall_cycles, 32'd3);
`endif

        // Flush during hold with in_valid asserted
        in_valid = 1; flush = 1; in_rd_addr = 5'd20; in_is_lui = 1; in_imm = 32'hFFFF_F000;
        tick();
        chk("flush_hold_valid", {31'd0, out_valid}, 32'd0);
        chk("flush_payload_kept", {27'd0, out_shamt}, 32'd31);
        // Flush with stage empty and ready: still no capture
        out_ready = 1;
        tick();
        chk("flush_nocap_valid", {31'd0, out_valid}, 32'd0);
        chk("flush_nocap_rd", {27'd0, out_rd}, 32'd8);
`ifdef EX_SHIFT_ISSUE_PERF_EN
        chk("stall_after_flush", stall_cycles, 32'd4);
`endif
        clear_inputs();

        // LUI
        in_valid = 1; in_is_lui = 1; in_imm = 32'h1234_5000; in_rs1_data = 32'hDEAD;
        in_rd_addr = 5'd10; in_reg_write = 1;
        tick();
        chk("lui_typ", {30'd0, out_typ}, 32'd3);
        chk("lui_a", out_a, 32'h1234_5000);
        chk("lui_is_shift", {31'd0, out_is_shift}, 32'd1);
        // Non-shift entry: shamt 0, typ 00
        clear_inputs();
        in_valid = 1; in_funct3 = 3'b000; in_use_imm = 1; in_imm = 32'h1F;
        in_rs1_data = 32'h99; in_rd_addr = 5'd11;
        tick();
        chk("nonshift_shamt", {27'd0, out_shamt}, 32'd0);
        chk("nonshift_typ", {30'd0, out_typ}, 32'd0);
        chk("nonshift_is_shift", {31'd0, out_is_shift}, 32'd0);
        clear_inputs();

        // Back-to-back stream of 8 SRLI
        for (int i = 0; i < 8; i++) begin
            in_valid = 1; in_funct3 = 3'b101; in_funct7b5 = 0; in_is_shift = 1;
            in_use_imm = 1; in_imm = i; in_rs1_data = i * 32'h100; in_rd_addr = 5'(i + 1);
            tick();
            chk("stream_valid", {31'd0, out_valid}, 32'd1);
            chk("stream_rd", {27'd0, out_rd}, 32'(i + 1));
            chk("stream_a", out_a, i * 32'h100);
            chk("stream_typ", {30'd0, out_typ}, 32'd1);
        end

        // Asynchronous reset mid-stream
        rst_n = 0;
        #1;
        chk("async_rst_valid", {31'd0, out_valid}, 32'd0);
        chk("async_rst_a", out_a, 32'd0);
`ifdef EX_SHIFT_ISSUE_PERF_EN
        chk("async_rst_stall", stall_cycles, 32'd0);
`endif
        clear_inputs();
        tick();
        rst_n = 1;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
